// File: rtl/mouse_receiver_if.sv
// Bundle between a PS/2 mouse receiver and its consumer: raw pad samples,
// start gating, and the received-byte strobe with its error code.
interface mouse_receiver_if;
  logic       READ_ENABLE;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [1:0] dbg_state;

  // BYTE_READY is a one-cycle valid strobe with no ready/backpressure: the
  // consumer must take BYTE_READ/BYTE_ERROR_CODE on the strobe cycle or
  // any later cycle before the next strobe, since both hold between strobes.
  modport master (
    output READ_ENABLE,
    output CLK_MOUSE_IN,
    output DATA_MOUSE_IN,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY,
    input  dbg_state
  );

  modport slave (
    input  READ_ENABLE,
    input  CLK_MOUSE_IN,
    input  DATA_MOUSE_IN,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY,
    output dbg_state
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 mouse byte receiver: synchronizes and debounces the PS/2 clock, shifts
// 11-bit frames on filtered falling edges, and reports parity/stop errors.
module mouse_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input logic              CLK,
  input logic              RESETN,
  mouse_receiver_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  clk_filt, clk_filt_d;
  logic                  fall, data_bit;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic                  parity_bit;
  logic [TW-1:0]         timeout_cnt;
  logic                  timeout_hit;
  logic [7:0]            byte_q;
  logic [1:0]            err_q;
  logic                  ready_q;

  // Input synchronizers and clock filter all rest at the PS/2 idle-high level.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_sr    <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], bus.CLK_MOUSE_IN};
      data_sync  <= {data_sync[0], bus.DATA_MOUSE_IN};
      filt_sr    <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
      if (filt_sr == '0) begin
        clk_filt <= 1'b0;
      end else if (filt_sr == '1) begin
        clk_filt <= 1'b1;
      end
      clk_filt_d <= clk_filt;
    end
  end

  assign fall        = ~clk_filt & clk_filt_d;
  assign data_bit    = data_sync[1];
  assign timeout_hit = (state != IDLE) && (timeout_cnt == TW'(TIMEOUT));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:      if (!data_bit && bus.READ_ENABLE) state_nxt = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        RX_PARITY: state_nxt = RX_STOP;
        RX_STOP:   state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // A stalled frame is abandoned silently; the last delivered byte is kept.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      parity_bit  <= 1'b0;
      timeout_cnt <= '0;
      byte_q      <= 8'h00;
      err_q       <= 2'b00;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (state == IDLE || fall) begin
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + TW'(1);
      end
      if (!timeout_hit && fall) begin
        case (state)
          IDLE: begin
            if (!data_bit && bus.READ_ENABLE) bit_cnt <= 3'd0;
          end
          RX_DATA: begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          RX_PARITY: begin
            parity_bit <= data_bit;
          end
          RX_STOP: begin
            byte_q  <= shift_reg;
            err_q   <= {~data_bit, ~(^shift_reg ^ parity_bit)};
            ready_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.BYTE_READ       = byte_q;
  assign bus.BYTE_ERROR_CODE = err_q;
  assign bus.BYTE_READY      = ready_q;
  assign bus.dbg_state       = state;

endmodule

// File: tb/tb_mouse_receiver.sv
// Bench for mouse_receiver: table-driven frames, hand-written corner sequences
// and random frames checked against an arithmetic PS/2 frame model.
module tb_mouse_receiver;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 600;
  localparam int HALF       = 30;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         re_mode;
    logic       expect_ready;
    logic [7:0] exp_byte;
    logic [1:0] exp_code;
  } vec_t;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  mouse_receiver_if bus ();

  mouse_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  // clock / reset block
  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation did not finish within 90000 cycles");
    $fatal(1);
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  int         stop_fall_cyc = 0;
  int         ready_cyc = -1;
  logic       prev_ready;
  logic [7:0] last_byte;
  logic [1:0] last_code;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: pops one expectation per strobe, and checks outputs hold
  always @(negedge CLK) begin
    if (!RESETN) begin
      last_byte  = 8'h00;
      last_code  = 2'b00;
      prev_ready = 1'b0;
    end else begin
      if (bus.BYTE_READY) begin
        logic [9:0] e;
        ready_cyc = cyc;
        if (prev_ready) begin
          n_err++;
          $display("FAIL strobe_width: got 2+ cycles expected 1");
        end
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ready: got byte %0h code %0h expected no strobe",
                   bus.BYTE_READ, bus.BYTE_ERROR_CODE);
        end else begin
          e = exp_q.pop_front();
          check("byte_read", 32'(bus.BYTE_READ), 32'(e[7:0]));
          check("error_code", 32'(bus.BYTE_ERROR_CODE), 32'(e[9:8]));
        end
        last_byte = bus.BYTE_READ;
        last_code = bus.BYTE_ERROR_CODE;
      end else if (bus.BYTE_READ !== last_byte || bus.BYTE_ERROR_CODE !== last_code) begin
        n_err++;
        $display("FAIL hold: got %0h/%0h expected %0h/%0h", bus.BYTE_READ,
                 bus.BYTE_ERROR_CODE, last_byte, last_code);
        last_byte = bus.BYTE_READ;
        last_code = bus.BYTE_ERROR_CODE;
      end
      prev_ready = bus.BYTE_READY;
    end
  end

  // reference model: odd parity over data+parity, stop bit must be 1
  function automatic logic [9:0] model_frame(logic [7:0] d, logic par, logic stop);
    int  ones;
    logic perr, serr;
    ones = $countones(d) + int'(par);
    perr = (ones % 2 == 0);
    serr = (stop == 1'b0);
    return {serr, perr, d};
  endfunction

  // driver tasks
  task automatic idle_cycles(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(logic b, bit is_stop);
    @(negedge CLK);
    bus.DATA_MOUSE_IN = b;
    idle_cycles(HALF);
    bus.CLK_MOUSE_IN = 1'b0;
    if (is_stop) stop_fall_cyc = cyc;
    idle_cycles(HALF);
    bus.CLK_MOUSE_IN = 1'b1;
  endtask

  task automatic clk_glitch(int low_len);
    bus.CLK_MOUSE_IN = 1'b0;
    idle_cycles(low_len);
    bus.CLK_MOUSE_IN = 1'b1;
    idle_cycles(20);
  endtask

  // re_mode: 0 enabled, 1 disabled for whole frame, 2 dropped after start bit
  task automatic send_frame(logic [7:0] d, logic par, logic stop, int nbits,
                            int re_mode, int glitch_after);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    bus.READ_ENABLE = (re_mode != 1);
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i], i == 10);
      if (i == 0 && re_mode == 2) bus.READ_ENABLE = 1'b0;
      if (i == glitch_after) begin
        for (int g = 0; g < 3; g++) clk_glitch(5);
      end
    end
    bus.READ_ENABLE = 1'b1;
  endtask

  task automatic finish_frame(string name);
    idle_cycles(FILTER_LEN + 20);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'hFA, 1'b1, 1'b1, 0, 1'b1, 8'hFA, 2'b00};
    tbl[1] = '{8'h08, 1'b1, 1'b1, 0, 1'b1, 8'h08, 2'b01};
    tbl[2] = '{8'h08, 1'b0, 1'b0, 0, 1'b1, 8'h08, 2'b10};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, 1, 1'b0, 8'h00, 2'b00};
    tbl[4] = '{8'h3C, 1'b1, 1'b1, 2, 1'b1, 8'h3C, 2'b00};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h00, 2'b00};
    tbl[6] = '{8'hFF, 1'b0, 1'b0, 0, 1'b1, 8'hFF, 2'b11};
    tbl[7] = '{8'h81, 1'b1, 1'b1, 0, 1'b1, 8'h81, 2'b00};

    bus.READ_ENABLE   = 1'b1;
    bus.CLK_MOUSE_IN  = 1'b1;
    bus.DATA_MOUSE_IN = 1'b1;
    idle_cycles(5);
    check("reset_byte", 32'(bus.BYTE_READ), 32'h00);
    check("reset_code", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("reset_ready", 32'(bus.BYTE_READY), 32'h0);
    check("reset_state", 32'(bus.dbg_state), 32'h0);
    RESETN = 1'b1;
    idle_cycles(FILTER_LEN + 10);

    // table-driven frames with latency check
    for (int i = 0; i < 8; i++) begin
      ready_cyc = -1;
      if (tbl[i].expect_ready) exp_q.push_back({tbl[i].exp_code, tbl[i].exp_byte});
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 11, tbl[i].re_mode, -1);
      finish_frame("missing_ready");
      if (tbl[i].expect_ready)
        check("ready_latency", 32'(ready_cyc - stop_fall_cyc), 32'(FILTER_LEN + 4));
      else
        check("re_off_no_ready", 32'(ready_cyc), 32'hFFFF_FFFF);
    end

    // stalled frame: start + 4 data bits, then PS/2 clock held high
    ready_cyc = -1;
    send_frame(8'h12, 1'b1, 1'b1, 5, 0, -1);
    idle_cycles(TIMEOUT / 2);
    check("pre_timeout_state", 32'(bus.dbg_state), 32'h1);
    idle_cycles(TIMEOUT);
    check("timeout_state", 32'(bus.dbg_state), 32'h0);
    check("timeout_no_ready", 32'(ready_cyc), 32'hFFFF_FFFF);
    check("timeout_byte_held", 32'(bus.BYTE_READ), 32'h81);
    exp_q.push_back(model_frame(8'h55, 1'b1, 1'b1));
    send_frame(8'h55, 1'b1, 1'b1, 11, 0, -1);
    finish_frame("missing_ready_after_timeout");

    // short glitches in IDLE with data low, then mid-frame glitches
    bus.DATA_MOUSE_IN = 1'b0;
    idle_cycles(5);
    for (int g = 0; g < 4; g++) clk_glitch(3);
    check("glitch_idle_state", 32'(bus.dbg_state), 32'h0);
    exp_q.push_back(model_frame(8'hAA, 1'b1, 1'b1));
    send_frame(8'hAA, 1'b1, 1'b1, 11, 0, 3);
    finish_frame("missing_ready_glitch");

    // reset after start + 5 data bits
    send_frame(8'hF4, 1'b0, 1'b1, 6, 0, -1);
    @(negedge CLK);
    RESETN = 1'b0;
    #1;
    check("midreset_byte", 32'(bus.BYTE_READ), 32'h00);
    check("midreset_code", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("midreset_ready", 32'(bus.BYTE_READY), 32'h0);
    check("midreset_state", 32'(bus.dbg_state), 32'h0);
    idle_cycles(5);
    RESETN = 1'b1;
    idle_cycles(FILTER_LEN + 10);
    exp_q.push_back(model_frame(8'hF4, 1'b0, 1'b1));
    send_frame(8'hF4, 1'b0, 1'b1, 11, 0, -1);
    finish_frame("missing_ready_after_reset");

    // random frames against the model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic par, stop;
      int re_mode;
      d       = 8'($urandom_range(0, 255));
      par     = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d ? 1'b0 : 1'b1);
      stop    = ($urandom_range(0, 7) != 0);
      re_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      exp_q.push_back(model_frame(d, par, stop));
      send_frame(d, par, stop, 11, re_mode, -1);
      finish_frame("missing_ready_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mouse_receiver.md
MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive agreeing CLK samples required to change the filtered PS/2 clock level.
REQ-002 Parameter TIMEOUT, default 50000: CLK cycles allowed between filtered falling edges inside a frame.
REQ-003 Port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 Port RESETN  input  1  reset, asynchronous, active-low.
REQ-005 Port READ_ENABLE  input  1  enables acceptance of a new frame start.
REQ-006 Port CLK_MOUSE_IN  input  1  raw PS/2 clock sampled from the CLK_MOUSE pad.
REQ-007 Port DATA_MOUSE_IN  input  1  raw PS/2 data sampled from the DATA_MOUSE pad.
REQ-008 Port BYTE_READ  output  8  last received data byte.
REQ-009 Port BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error, for BYTE_READ.
REQ-010 Port BYTE_READY  output  1  one-cycle strobe: BYTE_READ and BYTE_ERROR_CODE are newly valid.

Function
REQ-011 CLK_MOUSE_IN and DATA_MOUSE_IN SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 The synchronized clock SHALL feed a FILTER_LEN-deep shift register; the filtered-clock register goes 0 only when all entries are 0, goes 1 only when all entries are 1, and otherwise holds.
REQ-013 A falling-edge pulse SHALL be high for one cycle when the filtered clock is 0 and its one-cycle-delayed copy is 1; data is sampled from the synchronized data on that cycle.
REQ-014 FSM states SHALL be IDLE, RX_DATA, RX_PARITY, RX_STOP.
REQ-015 IDLE -> RX_DATA on an edge with data = 0 and READ_ENABLE = 1; bit counter cleared. An edge with data = 1, or with READ_ENABLE = 0, leaves the FSM in IDLE.
REQ-016 RX_DATA: each edge shifts data in LSB first; after the 8th bit -> RX_PARITY.
REQ-017 RX_PARITY: on an edge, capture the parity bit -> RX_STOP.
REQ-018 RX_STOP: on an edge, load BYTE_READ with the shifted byte; set BYTE_ERROR_CODE[0] = 1 if XOR(8 data bits, parity) = 0 (odd parity expected); set BYTE_ERROR_CODE[1] = 1 if the stop bit = 0; pulse BYTE_READY; -> IDLE.
REQ-019 BYTE_READY SHALL rise on the (FILTER_LEN+3)th rising CLK edge after the edge that first samples the stop-bit CLK_MOUSE_IN low, and stay high for exactly one cycle.
REQ-020 The byte SHALL still be delivered, with error bits set, when a parity or stop error occurs; the block never suppresses a completed frame.
REQ-021 Outside IDLE, a timeout counter SHALL increment every cycle and clear on each falling edge. When it reaches TIMEOUT: -> IDLE, no BYTE_READY, BYTE_READ and BYTE_ERROR_CODE unchanged.
REQ-022 Deasserting READ_ENABLE mid-frame SHALL NOT abort the frame; it gates only the start condition.
REQ-023 Clock glitches shorter than FILTER_LEN cycles SHALL produce no edge pulse and no state change.
REQ-024 BYTE_READ and BYTE_ERROR_CODE SHALL hold their values between BYTE_READY strobes.

Reset
REQ-025 RESETN low SHALL immediately force: FSM = IDLE, BYTE_READ = 0x00, BYTE_ERROR_CODE = 00, BYTE_READY = 0, bit and timeout counters = 0, synchronizers and filter = 1 (idle-high), filtered clock = 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release is received normally.

Verification
Test conditions: CLK 50 MHz, defaults, PS/2 half-period 2000 cycles, READ_ENABLE = 1 unless stated.
REQ-027 Frame 0xFA, parity 1, stop 1 -> exactly one BYTE_READY, BYTE_READ = 0xFA, BYTE_ERROR_CODE = 00, at the latency given in REQ-019.
REQ-028 Frame 0x08 with parity 1 (wrong) -> BYTE_READ = 0x08, BYTE_ERROR_CODE = 01; 0x08 with parity 0 and stop 0 -> BYTE_ERROR_CODE = 10.
REQ-029 Start bit plus 4 data bits, then clock held high -> no BYTE_READY within 60000 cycles; a following 0x55 frame (parity 1) -> BYTE_READ = 0x55, code 00.
REQ-030 3-cycle low glitches on CLK_MOUSE_IN in IDLE with data 0, and 5-cycle glitches mid-frame -> no extra bits; a subsequent 0xAA frame decodes as 0xAA.
REQ-031 READ_ENABLE = 0 during a full frame 0x3C -> no BYTE_READY. READ_ENABLE dropped after the start bit of 0x3C -> 0x3C delivered.
REQ-032 RESETN pulsed low after 5 data bits of a frame -> all outputs = 0 immediately; the next 0xF4 frame -> BYTE_READ = 0xF4, code 00.
